// File: rtl/sysarr_row_queue.sv
// Row queue feeding a systolic array: a DEPTH-entry circular FIFO of N-lane rows.
// An empty queue presents all-zero rows so idle cycles inject zeros into the array.
module sysarr_row_queue #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       push_valid,
  input  logic [N*WIDTH-1:0]         push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [N*WIDTH-1:0]         pop_data,
  input  logic                       pop_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       ovf_sticky
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = N * WIDTH;

  logic [RW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pushFire, popFire;

  // Pointers wrap explicitly so non-power-of-two depths behave identically.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_THRESH));
  assign push_ready  = !full;
  assign pop_valid   = !empty;
  assign pop_data    = empty ? '0 : mem_q[rdPtr_q];
  assign count       = count_q;
  assign ovf_sticky  = ovf_q;

  assign pushFire = push_valid && push_ready;
  assign popFire  = pop_valid && pop_ready;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (pushFire) wrPtr_d = nextPtr(wrPtr_q);
      if (popFire)  rdPtr_d = nextPtr(rdPtr_q);
      if (pushFire && !popFire) count_d = count_q + CW'(1);
      else if (popFire && !pushFire) count_d = count_q - CW'(1);
      if (push_valid && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (pushFire && !flush) mem_q[wrPtr_q] <= push_data;
  end

endmodule

// File: tb/tb_sysarr_row_queue.sv
// Directed bench for sysarr_row_queue: a DEPTH=4 instance for the main scenarios
// and a DEPTH=3 instance for wrap-around ordering.
module tb_sysarr_row_queue;

  logic        clk;
  logic        RST;

  logic        pushValid4, popReady4, flush4;
  logic [63:0] pushData4, popData4;
  logic        pushReady4, popValid4, full4, empty4, almostFull4, ovf4;
  logic [2:0]  count4;

  logic        pushValid3, popReady3, flush3;
  logic [63:0] pushData3, popData3;
  logic        pushReady3, popValid3, full3, empty3, almostFull3, ovf3;
  logic [1:0]  count3;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] ROW_A = 64'h0004_0003_0002_0001;
  localparam logic [63:0] ROW_B = 64'h0008_0007_0006_0005;
  localparam logic [63:0] ROW_C = 64'h000C_000B_000A_0009;
  localparam logic [63:0] ROW_X = 64'hDEAD_BEEF_CAFE_F00D;

  sysarr_row_queue #(.N(4), .WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .RST(RST),
    .push_valid(pushValid4), .push_data(pushData4), .push_ready(pushReady4),
    .pop_valid(popValid4), .pop_data(popData4), .pop_ready(popReady4),
    .flush(flush4), .count(count4), .full(full4), .empty(empty4),
    .almost_full(almostFull4), .ovf_sticky(ovf4)
  );

  sysarr_row_queue #(.N(4), .WIDTH(16), .DEPTH(3)) dut3 (
    .clk(clk), .RST(RST),
    .push_valid(pushValid3), .push_data(pushData3), .push_ready(pushReady3),
    .pop_valid(popValid3), .pop_data(popData3), .pop_ready(popReady3),
    .flush(flush3), .count(count3), .full(full3), .empty(empty3),
    .almost_full(almostFull3), .ovf_sticky(ovf3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] rowOf(input int k);
    return 64'h0100_0200_0300_0400 + 64'(k) * 64'h0001_0001_0001_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [63:0] pd, input logic pr, input logic fl);
    pushValid4 = pv;
    pushData4  = pd;
    popReady4  = pr;
    flush4     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST        = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    pushValid3 = 1'b0;
    pushData3  = '0;
    popReady3  = 1'b0;
    flush3     = 1'b0;
    #1 RST = 1'b1;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_empty",  64'(empty4),      64'd1);
    checkOutput("rst_full",   64'(full4),       64'd0);
    checkOutput("rst_af",     64'(almostFull4), 64'd0);
    checkOutput("rst_pready", 64'(pushReady4),  64'd1);
    checkOutput("rst_pvalid", 64'(popValid4),   64'd0);
    checkOutput("rst_pdata",  popData4,         64'd0);
    checkOutput("rst_count",  64'(count4),      64'd0);
    checkOutput("rst_ovf",    64'(ovf4),        64'd0);
    @(negedge clk);
    RST = 1'b0;

    $display("[TB] push A,B then drain");
    applyStimulus(1'b1, ROW_A, 1'b0, 1'b0);
    tick();
    checkOutput("first_push_count", 64'(count4), 64'd1);
    checkOutput("first_push_valid", 64'(popValid4), 64'd1);
    checkOutput("first_push_data", popData4, ROW_A);
    applyStimulus(1'b1, ROW_B, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ab_count", 64'(count4), 64'd2);
    checkOutput("ab_head", popData4, ROW_A);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("drain1_data", popData4, ROW_B);
    checkOutput("drain1_count", 64'(count4), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("drain2_empty", 64'(empty4), 64'd1);
    checkOutput("drain2_zero", popData4, 64'd0);

    $display("[TB] simultaneous push and pop at count 2");
    applyStimulus(1'b1, ROW_A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, ROW_B, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, ROW_C, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("pp_count", 64'(count4), 64'd2);
    checkOutput("pp_head", popData4, ROW_B);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("pp_tail", popData4, ROW_C);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("pp_empty", 64'(empty4), 64'd1);

    $display("[TB] fill to full, push while full with pop");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, rowOf(k), 1'b0, 1'b0);
      tick();
      if (k == 2) checkOutput("fill_af_at3", 64'(almostFull4), 64'd1);
      if (k == 1) checkOutput("fill_af_at2", 64'(almostFull4), 64'd0);
    end
    checkOutput("fill_full", 64'(full4), 64'd1);
    checkOutput("fill_pready", 64'(pushReady4), 64'd0);
    checkOutput("fill_ovf_pre", 64'(ovf4), 64'd0);
    applyStimulus(1'b1, ROW_X, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ovf_count", 64'(count4), 64'd3);
    checkOutput("ovf_sticky", 64'(ovf4), 64'd1);
    checkOutput("ovf_head", popData4, rowOf(1));
    tick();
    checkOutput("ovf_hold", 64'(ovf4), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush_count", 64'(count4), 64'd0);
    checkOutput("flush_ovf", 64'(ovf4), 64'd0);
    checkOutput("flush_zero", popData4, 64'd0);

    $display("[TB] flush with push and pop at count 3");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, rowOf(10 + k), 1'b0, 1'b0);
      tick();
    end
    checkOutput("f3_count", 64'(count4), 64'd3);
    applyStimulus(1'b1, ROW_X, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("fpp_count", 64'(count4), 64'd0);
    checkOutput("fpp_empty", 64'(empty4), 64'd1);
    tick();
    checkOutput("fpp_nothing", 64'(count4), 64'd0);

    $display("[TB] async reset at count 3");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, rowOf(20 + k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ar_count_pre", 64'(count4), 64'd3);
    #2 RST = 1'b1;
    #1;
    checkOutput("ar_empty", 64'(empty4), 64'd1);
    checkOutput("ar_zero", popData4, 64'd0);
    checkOutput("ar_count", 64'(count4), 64'd0);
    checkOutput("ar_pready", 64'(pushReady4), 64'd1);
    #1 RST = 1'b0;
    applyStimulus(1'b1, ROW_C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("ar_first_push", popData4, ROW_C);
    checkOutput("ar_first_count", 64'(count4), 64'd1);

    $display("[TB] DEPTH=3 interleaved wrap");
    for (int k = 0; k < 3; k++) begin
      pushValid3 = 1'b1;
      pushData3  = rowOf(k);
      tick();
    end
    pushValid3 = 1'b0;
    checkOutput("d3_full", 64'(full3), 64'd1);
    checkOutput("d3_count3", 64'(count3), 64'd3);
    checkOutput("d3_head0", popData3, rowOf(0));
    popReady3 = 1'b1;
    tick();
    for (int k = 3; k < 7; k++) begin
      checkOutput($sformatf("d3_head%0d", k - 2), popData3, rowOf(k - 2));
      pushValid3 = 1'b1;
      pushData3  = rowOf(k);
      popReady3  = 1'b1;
      tick();
      checkOutput($sformatf("d3_cnt%0d", k), 64'(count3), 64'd2);
    end
    pushValid3 = 1'b0;
    checkOutput("d3_head5", popData3, rowOf(5));
    tick();
    checkOutput("d3_head6", popData3, rowOf(6));
    tick();
    popReady3 = 1'b0;
    checkOutput("d3_empty", 64'(empty3), 64'd1);
    checkOutput("d3_zero", popData3, 64'd0);
    checkOutput("d3_ovf", 64'(ovf3), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysarr_row_queue.md
SYSARR_ROW_QUEUE -- requirements
Module: sysarr_row_queue

Interface
REQ-001 The block SHALL have parameter N, default 4, number of lanes (matrix row elements) per entry.
REQ-002 The block SHALL have parameter WIDTH, default 16, bits per lane.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of row entries; legal range DEPTH >= 2, any integer, not limited to powers of two.
REQ-004 The block SHALL have parameter AF_THRESH, default DEPTH-1, the occupancy at or above which almost_full asserts; legal range 1..DEPTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port push_valid, input, 1 bit: producer offers a row.
REQ-008 The block SHALL have port push_data, input, N*WIDTH bits: offered row; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port push_ready, output, 1 bit: a row can be accepted.
REQ-010 The block SHALL have port pop_valid, output, 1 bit: the head row is available.
REQ-011 The block SHALL have port pop_data, output, N*WIDTH bits: the head row, same lane packing as push_data.
REQ-012 The block SHALL have port pop_ready, input, 1 bit: consumer takes the head row.
REQ-013 The block SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-015 The block SHALL have ports full, empty and almost_full, each output, 1 bit: occupancy status flags.
REQ-016 The block SHALL have port ovf_sticky, output, 1 bit: sticky flag indicating a push was offered while full.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries addressed by a write pointer and a read pointer, each wrapping from DEPTH-1 to 0.
REQ-018 A push handshake SHALL occur when push_valid and push_ready are both high on a clk edge; push_data is written at the write pointer and the write pointer advances.
REQ-019 A pop handshake SHALL occur when pop_valid and pop_ready are both high on a clk edge; the read pointer advances.
REQ-020 The block SHALL drive push_ready = !full, purely from registered state, with no bypass: a full queue rejects a push even when a pop occurs in the same cycle.
REQ-021 The block SHALL drive pop_valid = !empty.
REQ-022 The block SHALL drive pop_data from the entry at the read pointer when not empty, and all zeros when empty, so that idle cycles feed zeros into the array.
REQ-023 Latency SHALL be one cycle: a row pushed into an empty queue at edge k appears on pop_data with pop_valid high after edge k.
REQ-024 A simultaneous push and pop SHALL perform both operations and leave count unchanged.
REQ-025 The count output SHALL increment on a push-only cycle, decrement on a pop-only cycle, and never exceed DEPTH or go below 0.
REQ-026 The status flags SHALL be combinational from count: full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AF_THRESH).
REQ-027 Entries SHALL be dequeued in exact push order (FIFO), including across pointer wrap-around.
REQ-028 When flush is high at a clk edge, both pointers and count SHALL go to 0, and any push or pop in that cycle SHALL be ignored; flush takes priority.
REQ-029 A flush SHALL NOT clear the storage array; pop_data is nonetheless zero afterwards per REQ-022.
REQ-030 The block SHALL set ovf_sticky on any edge where push_valid is high while full is high, and hold it until reset or flush clears it.
REQ-031 Behaviour SHALL be identical for any legal DEPTH, including non-power-of-two values such as 3 or 5.

Reset
REQ-032 While RST is high, asynchronously, the pointers, count and ovf_sticky SHALL be 0.
REQ-033 During reset the outputs SHALL read: empty=1, full=0, almost_full=0 (AF_THRESH>=1), push_ready=1, pop_valid=0, pop_data=0.
REQ-034 Reset asserted mid-operation SHALL discard all contents immediately.
REQ-035 The first push SHALL be accepted on the first clk edge after RST deasserts.
REQ-036 The storage array SHALL require no reset.

Verification
REQ-037 The bench SHALL cover: reset, then push rows A=0x0004_0003_0002_0001 and B=0x0008_0007_0006_0005 with pop_ready=0 -> count=2, pop_data=A; then pop_ready=1 for 2 cycles -> A then B out, then empty=1 and pop_data=0.
REQ-038 The bench SHALL cover: DEPTH=3, 7 rows pushed and popped interleaved -> order preserved across wrap, count never exceeds 3.
REQ-039 The bench SHALL cover: filling to full (DEPTH=4) with push_valid held plus pop_ready=1 in the same cycle -> push rejected, count 4->3, ovf_sticky=1; a subsequent flush -> count=0, ovf_sticky=0.
REQ-040 The bench SHALL cover: count=2, push and pop in the same cycle -> count stays 2 and the new row lands at the tail.
REQ-041 The bench SHALL cover: flush asserted together with push_valid and pop_ready at count=3 -> count=0, nothing enqueued.
REQ-042 The bench SHALL cover: RST pulsed asynchronously at count=3, between clock edges -> empty=1 and pop_data=0 immediately, before the next edge.
